// File: rtl/net_hpwl_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : net_hpwl_pkg
// Brief   : Shared types for the HPWL cost evaluator: FSM state encoding,
//           per-net bounding-box record and half-perimeter helper.
//           Optional feature macro used by this block: HPWL_NET_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
package net_hpwl_pkg;

  // Unsigned placed-pin coordinate width
  localparam int COORD_W = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    SUM   = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
    logic               seen;
  } bbox_t;

  // Half-perimeter of a box; an empty box contributes nothing. One extra bit
  // holds the worst case (full width plus full height).
  function automatic logic [COORD_W:0] half_perim(input bbox_t b);
    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;
    half_perim = '0;
    dx = {1'b0, b.xmax} - {1'b0, b.xmin};
    dy = {1'b0, b.ymax} - {1'b0, b.ymin};
    if (b.seen) begin
      half_perim = dx + dy;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/net_hpwl_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module  : net_hpwl_accumulator_if
// Brief   : Pin-record stream, result handshake and status signals of the
//           HPWL evaluator. Per-net statistics appear with HPWL_NET_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
interface net_hpwl_accumulator_if #(
  parameter int NET_W = 4,
  parameter int SUM_W = net_hpwl_pkg::COORD_W + 1 + NET_W
);
  logic                            start;
  logic                            pin_valid;
  logic                            pin_ready;
  logic [NET_W-1:0]                pin_net;
  logic [net_hpwl_pkg::COORD_W-1:0] pin_x;
  logic [net_hpwl_pkg::COORD_W-1:0] pin_y;
  logic                            pin_last;
  logic                            hpwl_valid;
  logic                            hpwl_ready;
  logic [SUM_W-1:0]                hpwl;
  logic                            busy;
  logic                            err_net;
`ifdef HPWL_NET_STATS_EN
  logic [net_hpwl_pkg::COORD_W:0]  max_net_hpwl;
  logic [NET_W-1:0]                max_net_id;
`endif

  // Placer side: issues pins, collects the cost
  modport master (
    output start, pin_valid, pin_net, pin_x, pin_y, pin_last, hpwl_ready,
`ifdef HPWL_NET_STATS_EN
    input  max_net_hpwl, max_net_id,
`endif
    input  pin_ready, hpwl_valid, hpwl, busy, err_net
  );

  // Evaluator side
  modport slave (
    input  start, pin_valid, pin_net, pin_x, pin_y, pin_last, hpwl_ready,
`ifdef HPWL_NET_STATS_EN
    output max_net_hpwl, max_net_id,
`endif
    output pin_ready, hpwl_valid, hpwl, busy, err_net
  );
endinterface
`default_nettype wire

// File: rtl/net_hpwl_accumulator_bbox_table.sv
`default_nettype none
// ============================================================================
// Module  : net_bbox_table
// Brief   : Flop array of per-net bounding boxes. Single-cycle
//           read-modify-write update port, whole-table clear, indexed read.
// Revision: 1.0 - initial release
// ============================================================================
module net_bbox_table
  import net_hpwl_pkg::*;
#(
  parameter int NUM_NETS = 16,
  parameter int NET_W    = $clog2(NUM_NETS)
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               clr_i,
  input  wire logic               wr_en_i,
  input  wire logic [NET_W-1:0]   wr_idx_i,
  input  wire logic [COORD_W-1:0] wr_x_i,
  input  wire logic [COORD_W-1:0] wr_y_i,
  input  wire logic [NET_W-1:0]   rd_idx_i,
  output bbox_t                   rd_box_o
);

  bbox_t tbl_q [NUM_NETS];

  // Clear marks every box empty; an update seeds or stretches one box
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      for (int n = 0; n < NUM_NETS; n++) begin
        tbl_q[n].seen <= 1'b0;
      end
    end else if (wr_en_i) begin
      for (int n = 0; n < NUM_NETS; n++) begin
        if (wr_idx_i == NET_W'(n)) begin
          if (!tbl_q[n].seen) begin
            tbl_q[n] <= '{xmin: wr_x_i, xmax: wr_x_i, ymin: wr_y_i, ymax: wr_y_i, seen: 1'b1};
          end else begin
            if (wr_x_i < tbl_q[n].xmin) tbl_q[n].xmin <= wr_x_i;
            if (wr_x_i > tbl_q[n].xmax) tbl_q[n].xmax <= wr_x_i;
            if (wr_y_i < tbl_q[n].ymin) tbl_q[n].ymin <= wr_y_i;
            if (wr_y_i > tbl_q[n].ymax) tbl_q[n].ymax <= wr_y_i;
          end
        end
      end
    end
  end

  // Indexed read for the summing sweep
  always_comb begin
    rd_box_o = '0;
    for (int n = 0; n < NUM_NETS; n++) begin
      if (rd_idx_i == NET_W'(n)) rd_box_o = tbl_q[n];
    end
  end

endmodule
`default_nettype wire

// File: rtl/net_hpwl_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : net_hpwl_accumulator
// Brief   : Accumulates per-net bounding boxes from a pin stream, then sweeps
//           all nets to produce total half-perimeter wirelength.
//           Optional macro HPWL_NET_STATS_EN adds largest-net statistics.
// Revision: 1.0 - initial release
// ============================================================================
module net_hpwl_accumulator
  import net_hpwl_pkg::*;
#(
  parameter int NUM_NETS = 16,
  parameter int NET_W    = $clog2(NUM_NETS),
  parameter int SUM_W    = COORD_W + 1 + NET_W
) (
  input wire logic               clk,
  input wire logic               rst_n,
  net_hpwl_accumulator_if.slave  bus
);

  localparam logic [NET_W:0]   NUM_NETS_X = (NET_W + 1)'(NUM_NETS);
  localparam logic [NET_W-1:0] LAST_IDX   = NET_W'(NUM_NETS - 1);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [NET_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  logic             pin_fire;
  logic             in_range;
  logic             start_ok;
  bbox_t            rd_box;
  logic [COORD_W:0] net_hp;

  assign pin_fire = (state_q == ACCUM) && bus.pin_valid;
  assign in_range = {1'b0, bus.pin_net} < NUM_NETS_X;
  assign start_ok = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign net_hp   = half_perim(rd_box);

  net_bbox_table #(
    .NUM_NETS (NUM_NETS),
    .NET_W    (NET_W)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q == CLEAR),
    .wr_en_i  (pin_fire && in_range),
    .wr_idx_i (bus.pin_net),
    .wr_x_i   (bus.pin_x),
    .wr_y_i   (bus.pin_y),
    .rd_idx_i (idx_q),
    .rd_box_o (rd_box)
  );

  // State, running sum, sweep index and error flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a start in DONE doubles as the result accept
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = CLEAR;
          sum_d   = '0;
          err_d   = 1'b0;
        end
      end
      CLEAR: state_d = ACCUM;
      ACCUM: begin
        if (pin_fire) begin
          if (!in_range) err_d = 1'b1;
          if (bus.pin_last) begin
            state_d = SUM;
            idx_d   = '0;
          end
        end
      end
      SUM: begin
        sum_d = sum_q + SUM_W'(net_hp);
        idx_d = idx_q + NET_W'(1);
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (start_ok) begin
          state_d = CLEAR;
          sum_d   = '0;
          err_d   = 1'b0;
        end else if (bus.hpwl_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pin_ready  = (state_q == ACCUM);
  assign bus.hpwl_valid = (state_q == DONE);
  assign bus.busy       = (state_q == CLEAR) || (state_q == ACCUM) || (state_q == SUM);
  assign bus.hpwl       = sum_q;
  assign bus.err_net    = err_q;

`ifdef HPWL_NET_STATS_EN
  logic [COORD_W:0] max_hp_q;
  logic [NET_W-1:0] max_id_q;

  // Track the largest contribution; strict compare keeps the lowest id on ties
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      max_hp_q <= '0;
      max_id_q <= '0;
    end else if ((state_q == SUM) && (net_hp > max_hp_q)) begin
      max_hp_q <= net_hp;
      max_id_q <= idx_q;
    end
  end

  assign bus.max_net_hpwl = max_hp_q;
  assign bus.max_net_id   = max_id_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_net_hpwl_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_net_hpwl_accumulator
// Brief   : Self-checking bench for net_hpwl_accumulator against a per-net
//           min/max reference model. A 5-bit net id makes out-of-range ids
//           expressible with 16 nets.
// Revision: 1.0 - initial release
// ============================================================================
module tb_net_hpwl_accumulator;

  localparam int NUM_NETS = 16;
  localparam int NET_W    = 5;
  localparam int COORD_W  = 12;
  localparam int SUM_W    = COORD_W + 1 + NET_W;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  int q_net[$];
  int q_x[$];
  int q_y[$];

  net_hpwl_accumulator_if #(.NET_W(NET_W), .SUM_W(SUM_W)) bus ();

  net_hpwl_accumulator #(
    .NUM_NETS (NUM_NETS),
    .NET_W    (NET_W),
    .SUM_W    (SUM_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_pins();
    q_net.delete();
    q_x.delete();
    q_y.delete();
  endtask

  task automatic push(input int n, input int x, input int y);
    q_net.push_back(n);
    q_x.push_back(x);
    q_y.push_back(y);
  endtask

  // Reference: for each net, bounding box over every in-range pin on it
  function automatic void ref_model(output longint h, output bit e, output int mx, output int mid);
    bit any;
    int xl, xh, yl, yh, c;
    h = 0; e = 0; mx = 0; mid = 0;
    for (int n = 0; n < NUM_NETS; n++) begin
      any = 0; xl = 0; xh = 0; yl = 0; yh = 0;
      for (int k = 0; k < q_net.size(); k++) begin
        if (q_net[k] == n) begin
          if (!any) begin
            xl = q_x[k]; xh = q_x[k]; yl = q_y[k]; yh = q_y[k]; any = 1;
          end else begin
            if (q_x[k] < xl) xl = q_x[k];
            if (q_x[k] > xh) xh = q_x[k];
            if (q_y[k] < yl) yl = q_y[k];
            if (q_y[k] > yh) yh = q_y[k];
          end
        end
      end
      if (any) begin
        c = (xh - xl) + (yh - yl);
        h += c;
        if (c > mx) begin mx = c; mid = n; end
      end
    end
    for (int k = 0; k < q_net.size(); k++) begin
      if (q_net[k] >= NUM_NETS) e = 1;
    end
  endfunction

  task automatic do_start(input string tag);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_clr_hpwl"}, bus.hpwl, 0);
    check({tag, "_clr_err"}, bus.err_net, 0);
    @(posedge clk); #1;
    check({tag, "_rdy"}, bus.pin_ready, 1);
  endtask

  task automatic send_pin(input int n, input int x, input int y, input bit last);
    bus.pin_net   = NET_W'(n);
    bus.pin_x     = COORD_W'(x);
    bus.pin_y     = COORD_W'(y);
    bus.pin_last  = last;
    bus.pin_valid = 1'b1;
    @(posedge clk); #1;
    bus.pin_valid = 1'b0;
    bus.pin_last  = 1'b0;
  endtask

  // Full evaluation of the queued pins; exp_c < 0 means model-only
  task automatic run_eval(input string tag, input bit accept, input longint exp_c, input bit poke);
    longint eh;
    bit     ee;
    int     emx, eid, lat;
    ref_model(eh, ee, emx, eid);
    do_start(tag);
    for (int k = 0; k < q_net.size(); k++) begin
      send_pin(q_net[k], q_x[k], q_y[k], k == q_net.size() - 1);
    end
    lat = 1;
    while (!bus.hpwl_valid && lat < 200) begin
      bus.start = poke && (lat == 4);
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, lat, NUM_NETS + 1);
    check({tag, "_hpwl"}, bus.hpwl, eh);
    if (exp_c >= 0) check({tag, "_hpwl_c"}, bus.hpwl, exp_c);
    check({tag, "_err"}, bus.err_net, ee);
`ifdef HPWL_NET_STATS_EN
    check({tag, "_maxhp"}, bus.max_net_hpwl, emx);
    check({tag, "_maxid"}, bus.max_net_id, eid);
`endif
    if (accept) begin
      bus.hpwl_ready = 1'b1;
      @(posedge clk); #1;
      bus.hpwl_ready = 1'b0;
      check({tag, "_acc"}, bus.hpwl_valid, 0);
    end
  endtask

  initial begin
    logic [SUM_W-1:0] held;
    int np;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.pin_valid = 1'b1; bus.pin_net = '0;
    bus.pin_x = '0; bus.pin_y = '0; bus.pin_last = 1'b0; bus.hpwl_ready = 1'b0;

    // Reset with pin_valid asserted
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", bus.pin_ready, 0);
    check("rst_vld", bus.hpwl_valid, 0);
    check("rst_hpwl", bus.hpwl, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err_net, 0);
`ifdef HPWL_NET_STATS_EN
    check("rst_maxhp", bus.max_net_hpwl, 0);
    check("rst_maxid", bus.max_net_id, 0);
`endif
    rst_n = 1'b1; bus.pin_valid = 1'b0;
    @(posedge clk); #1;

    // Three pins on one net
    clear_pins(); push(3, 10, 20); push(3, 40, 5); push(3, 25, 30);
    run_eval("t1", 1, 55, 0);

    // Two single-pin nets
    clear_pins(); push(0, 7, 7); push(1, 100, 100);
    run_eval("t2", 1, 0, 0);

    // Corner coordinates plus an out-of-range id
    clear_pins(); push(2, 0, 0); push(15, 4095, 4095); push(15, 0, 0); push(20, 9, 9); push(2, 0, 0);
    run_eval("t3", 1, 8190, 0);

    // Result held while not accepted
    clear_pins(); push(7, 0, 0); push(7, 1000, 2000);
    run_eval("t4", 0, 3000, 0);
    held = bus.hpwl;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("t4_hold", bus.hpwl, held);
      check("t4_hold_vld", bus.hpwl_valid, 1);
    end

    // Start from DONE; old box on net 7 must be gone
    clear_pins(); push(7, 500, 500);
    run_eval("t5", 1, 0, 0);

    // Reset in the middle of accumulation
    do_start("t6a");
    send_pin(6, 100, 100, 0);
    send_pin(6, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_rdy", bus.pin_ready, 0);
    check("t6_rst_hpwl", bus.hpwl, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_pins(); push(5, 1, 1); push(5, 3, 4);
    run_eval("t6", 1, 5, 0);

    // Randomised candidates, first one also pulses start while busy
    for (int it = 0; it < 8; it++) begin
      clear_pins();
      np = $urandom_range(1, 14);
      for (int k = 0; k < np; k++) begin
        push($urandom_range(0, 17),
             ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 4095),
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 4095));
      end
      run_eval($sformatf("rnd%0d", it), 1, -1, it == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
